serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor, diff = a - b, computed LSB-first over WIDTH clocks.
//   Uses one full-subtractor cell and a borrow flip-flop.
//   Serves as the arithmetic inverse of the team's ripple adder.
//   Sits beside the adder in the arithmetic library; intended for area-constrained datapaths.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range >= 1
// PORTS
//   clk         in   1      single clock; all state updates on rising edge
//   rst_n       in   1      reset, asynchronous assert, active-low
//   start       in   1      request; sampled only while ready=1
//   a           in   WIDTH  minuend; captured on the accepted start
//   b           in   WIDTH  subtrahend; captured on the accepted start
//   ready       out  1      1 in IDLE; start is accepted only in this state
//   busy        out  1      1 in SHIFT
//   done        out  1      one-cycle pulse; diff/borrow_out valid from this cycle on
//   diff        out  WIDTH  a - b mod 2^WIDTH
//   borrow_out  out  1      final borrow; 1 iff a < b (unsigned)
//   overflow    out  1      only with SERIAL_SUB_OVF_EN; signed overflow flag
// BEHAVIOUR
//   Reset values: ready=1, busy=0, done=0, diff=0, borrow_out=0, overflow=0; state=IDLE.
//   Internal state: operand shift regs, borrow FF, bit counter of $clog2(WIDTH+1) bits.
//   FSM transitions:
//     IDLE -> SHIFT when start=1: capture a, b; clear borrow FF and counter.
//     SHIFT -> SHIFT for WIDTH cycles.
//     SHIFT -> DONE after bit WIDTH-1 is processed.
//     DONE -> IDLE unconditionally after 1 cycle.
//   Each SHIFT cycle, with x=a_sr[0], y=b_sr[0], bi=borrow FF:
//     d  = x ^ y ^ bi
//     bo = (~x & y) | (~x & bi) | (y & bi)
//     d enters diff at the MSB; diff shifts right, so after WIDTH shifts diff[0] holds bit 0.
//     a_sr and b_sr shift right; borrow FF <= bo.
//   Result update:
//     diff is cleared on an accepted start.
//     borrow_out updates on the SHIFT->DONE edge.
//   Latency: start accepted at edge t -> done=1 in the cycle following edge t+WIDTH+1.
//   Result retention: diff, borrow_out (and overflow) hold until the next accepted start.
//   start while busy or in DONE is ignored (not queued); a and b may change freely then.
//   Back-to-back: start in the cycle after done is accepted (ready=1 again).
//   Reset mid-operation: immediate abort, all outputs to reset values; no partial result kept.
//   WIDTH=1: a single SHIFT cycle; no other special case.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     overflow port present.
//     overflow = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), using the captured operand MSBs.
//     Registered together with borrow_out; cleared on an accepted start.
//   SERIAL_SUB_OVF_EN undefined: port, MSB capture regs and logic absent.
// STRUCTURE
//   Package serial_sub_pkg holds:
//     state enum {IDLE, SHIFT, DONE} as a 2-bit typedef
//     localparam helper CNT_W(width) = $clog2(width+1)
//   Sub-module full_subtractor (x, y, bin -> d, bout): purely combinational, one instance.
//   Top keeps FSM, shift registers, borrow FF and counter.
// TESTING
//   start, a=100, b=37 (WIDTH=8) -> done 9 cycles after accept; diff=63, borrow_out=0.
//   a=5, b=10 -> diff=251, borrow_out=1; a=0, b=0 -> diff=0, borrow_out=0.
//   a=255, b=255 -> diff=0, borrow_out=0; a=0, b=1 -> diff=255, borrow_out=1.
//   OVF_EN, a=8'h80, b=8'h01 -> diff=8'h7F, overflow=1.
//   OVF_EN, a=8'h7F, b=8'hFF -> diff=8'h80, overflow=1; a=3, b=1 -> overflow=0.
//   start pulsed mid-SHIFT with new a/b -> ignored; first result unchanged, single done pulse.
//   rst_n low at 4th SHIFT cycle -> next edge ready=1, diff=0, no done; new start works.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   state_t  : FSM encoding {IDLE, SHIFT, DONE}, 2 bits.
//   CNT_W()  : width of a bit counter that must hold values 0..width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit full subtractor cell, purely combinational: d = x - y - bin.
//   Ports:
//     x    in   minuend bit
//     y    in   subtrahend bit
//     bin  in   borrow in
//     d    out  difference bit
//     bout out  borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b mod 2^WIDTH, processed
//   LSB-first through a single full_subtractor cell and a borrow flip-flop.
//   Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is
//   defined; the default build omits the port and its logic.
//   Ports:
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset
//     start       in   request, sampled only while ready=1
//     a, b        in   operands, captured on the accepted start
//     ready       out  1 while idle
//     busy        out  1 while shifting
//     done        out  one-cycle pulse, results valid from this cycle on
//     diff        out  a - b mod 2^WIDTH
//     borrow_out  out  1 iff a < b (unsigned)
//     overflow    out  signed overflow (SERIAL_SUB_OVF_EN only)
//
//   state | meaning
//   IDLE  | waiting for start; results of last operation held
//   SHIFT | one bit per cycle for WIDTH cycles, then one cycle to commit
//   DONE  | done pulse; returns to IDLE next cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int               CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bo_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            overflow <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // The counter reaches WIDTH after the last bit; that extra cycle
          // commits the final borrow (and overflow) and raises done.
          if (cnt == LAST) begin
            borrow_out <= borrow;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb);
`endif
          end else begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= bo_bit;
            // new bit enters at the MSB; after WIDTH shifts bit 0 is at diff[0]
            diff   <= (diff >> 1) | ({WIDTH{d_bit}} & MSB_MASK);
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] diff;
    logic         brw;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .overflow   (overflow),
`endif
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t       e;
    logic [W:0] r;
    int         sd;
    r      = {1'b0, av} - {1'b0, bv};
    e.diff = r[W-1:0];
    e.brw  = r[W];
    sd     = int'($signed(av)) - int'($signed(bv));
    e.ovf  = (sd > 127) || (sd < -128);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit b2b, input bit poke);
    exp_t e;
    int   cyc;
    int   pulses;
    if (!b2b) @(negedge clk);
    chk("ready_before", 32'(ready), 32'd1);
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (poke && cyc == 3) begin
        start = 1'b1;
        a = ~av;
        b = av;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("latency", 32'(cyc), 32'd9);
    chk("diff", 32'(diff), 32'(e.diff));
    chk("borrow", 32'(borrow_out), 32'(e.brw));
`ifdef SERIAL_SUB_OVF_EN
    chk("overflow", 32'(overflow), 32'(e.ovf));
`endif
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
    chk("diff_hold", 32'(diff), 32'(e.diff));
    if (poke) begin
      pulses = 0;
      repeat (12) begin
        @(negedge clk);
        if (done === 1'b1) pulses++;
      end
      chk("no_extra_done", 32'(pulses), 32'd0);
      chk("diff_after_poke", 32'(diff), 32'(e.diff));
    end
  endtask

  initial begin
    int pulses;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_overflow", 32'(overflow), 32'd0);
`endif
    rst_n = 1'b1;

    do_op(8'd100, 8'd37, 1'b0, 1'b0);
    do_op(8'd5,   8'd10, 1'b1, 1'b0);
    do_op(8'd0,   8'd0,  1'b1, 1'b0);
    do_op(8'd255, 8'd255, 1'b0, 1'b0);
    do_op(8'd0,   8'd1,  1'b0, 1'b0);
    do_op(8'h80,  8'h01, 1'b0, 1'b0);
    do_op(8'h7F,  8'hFF, 1'b1, 1'b0);
    do_op(8'd3,   8'd1,  1'b0, 1'b0);
    do_op(8'd200, 8'd55, 1'b0, 1'b1);

    // abort in the 4th SHIFT cycle
    @(negedge clk);
    a = 8'd77;
    b = 8'd12;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    do_op(8'd9, 8'd4, 1'b1, 1'b0);
    do_op(8'd17, 8'd200, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
